shift_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 8-bit shift register. It buffers multi-beat shift commands in a small FIFO and drives the register's contrl/datain/setdata inputs one operation per clock. It keeps a shadow copy of the register contents, so when no command is running it can hold the register steady.

---
 rtl/shift_cmd_seq.sv | 115 +++++++++++
 tb/tb_shift_cmd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: FIFO-buffered multi-beat command sequencer driving an 8-bit shift register.
// Optional SHIFT_SEQ_DONE_EN adds a one-cycle done pulse after each command's final beat.
module shift_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [7:0]       cmd_data,
  output logic [2:0]       sr_contrl,
  output logic             sr_datain,
  output logic [7:0]       sr_setdata,
  output logic             busy,
  output logic [7:0]       q_model
`ifdef SHIFT_SEQ_DONE_EN
  ,
  output logic             done
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + CNT_W + 8;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_fill;
  logic [CNT_W-1:0] r_left;
  logic [2:0]       r_idx, r_op, r_contrl;
  logic [7:0]       r_data, r_q, r_setdata;
  logic             r_datain;
  logic             w_empty, w_push, w_pop, w_last;
  logic [2:0]       w_hop, w_nidx;
  logic [CNT_W-1:0] w_hcnt;
  logic [7:0]       w_hdata, w_qn;
  assign w_empty   = r_fill == '0;
  assign cmd_ready = r_fill != (AW+1)'(DEPTH);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_last    = (r_state == RUN) && (r_left == '0);
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_last);
  assign {w_hop, w_hcnt, w_hdata} = r_mem[r_rp];
  assign w_nidx    = r_idx + 3'd1;
  assign sr_contrl  = r_contrl;
  assign sr_datain  = r_datain;
  assign sr_setdata = r_setdata;
  assign q_model    = r_q;
  assign busy       = (r_state == RUN) || !w_empty;
  // Mirror of the shift register: what Q becomes after executing the op now on sr_*
  always_comb begin
    w_qn = {r_q[6:0], r_q[7]};
    case (r_contrl)
      3'b000:  w_qn = 8'h00;
      3'b001:  w_qn = r_setdata;
      3'b010:  w_qn = {1'b0, r_q[7:1]};
      3'b011:  w_qn = {r_q[6:0], 1'b0};
      3'b100:  w_qn = {r_q[7], r_q[7:1]};
      3'b101:  w_qn = {r_datain, r_q[6:0]};
      3'b110:  w_qn = {r_q[0], r_q[7:1]};
      default: w_qn = {r_q[6:0], r_q[7]};
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {cmd_op, cmd_cnt, cmd_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_fill    <= '0;
      r_left    <= '0;
      r_idx     <= '0;
      r_op      <= '0;
      r_data    <= '0;
      r_q       <= '0;
      r_contrl  <= '0;
      r_datain  <= 1'b0;
      r_setdata <= '0;
    end else begin
      r_q    <= w_qn;
      r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_pop) begin
        r_state   <= RUN;
        r_op      <= w_hop;
        r_data    <= w_hdata;
        r_left    <= w_hcnt;
        r_idx     <= '0;
        r_contrl  <= w_hop;
        r_datain  <= (w_hop == 3'b101) & w_hdata[0];
        r_setdata <= (w_hop == 3'b001) ? w_hdata : 8'h00;
      end else if ((r_state == RUN) && !w_last) begin
        r_left   <= r_left - CNT_W'(1);
        r_idx    <= w_nidx;
        r_datain <= (r_op == 3'b101) & r_data[w_nidx];
      end else begin
        // Hold beat re-writes Q[7] with its own post-edge value, leaving Q steady
        r_state   <= IDLE;
        r_contrl  <= 3'b101;
        r_datain  <= w_qn[7];
        r_setdata <= 8'h00;
      end
    end
  end
`ifdef SHIFT_SEQ_DONE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else done <= w_last;
  end
`endif
endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq: directed self-checking bench for shift_cmd_seq (DEPTH=4, CNT_W=4).
module tb_shift_cmd_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] cmd_data;
  logic [2:0] sr_contrl;
  logic       sr_datain;
  logic [7:0] sr_setdata;
  logic       busy;
  logic [7:0] q_model;
`ifdef SHIFT_SEQ_DONE_EN
  logic       done;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int acc, beats;

  shift_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .sr_contrl(sr_contrl), .sr_datain(sr_datain), .sr_setdata(sr_setdata),
    .busy(busy), .q_model(q_model)
`ifdef SHIFT_SEQ_DONE_EN
    , .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] c, input logic [7:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_cnt   = c;
    cmd_data  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 3'b000, 4'd0, 8'h00);
    #1;
    chk("rst_contrl", sr_contrl, 3'b000);
    chk("rst_q", q_model, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    tick();
    tick();
    chk("rst_contrl_edge", sr_contrl, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("idle_contrl", sr_contrl, 3'b101);
    chk("idle_datain", sr_datain, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("idle5_contrl", sr_contrl, 3'b101);
    chk("idle5_q", q_model, 8'h00);
    chk("idle5_busy", busy, 1'b0);
    // load A5
    drive(1, 3'b001, 4'd0, 8'hA5);
    tick();
    drive(0, 3'b000, 4'd0, 8'h00);
    chk("ld_busy_k", busy, 1'b1);
    chk("ld_contrl_k", sr_contrl, 3'b101);
    tick();
    chk("ld_contrl_k1", sr_contrl, 3'b001);
    chk("ld_setdata_k1", sr_setdata, 8'hA5);
    chk("ld_q_k1", q_model, 8'h00);
    tick();
    chk("ld_q_k2", q_model, 8'hA5);
    chk("ld_hold_contrl", sr_contrl, 3'b101);
    chk("ld_hold_datain", sr_datain, 1'b1);
    chk("ld_hold_setdata", sr_setdata, 8'h00);
    chk("ld_busy_k2", busy, 1'b0);
`ifdef SHIFT_SEQ_DONE_EN
    chk("ld_done", done, 1'b1);
`endif
    tick();
    chk("ld_q_k3", q_model, 8'hA5);
`ifdef SHIFT_SEQ_DONE_EN
    chk("ld_done_off", done, 1'b0);
`endif
    // rotate right x3
    drive(1, 3'b110, 4'd2, 8'h00);
    tick();
    drive(0, 3'b000, 4'd0, 8'h00);
    tick();
    chk("ror_contrl", sr_contrl, 3'b110);
    chk("ror_q0", q_model, 8'hA5);
    tick();
    chk("ror_q1", q_model, 8'hD2);
    tick();
    chk("ror_q2", q_model, 8'h69);
    tick();
    chk("ror_q3", q_model, 8'hB4);
    chk("ror_hold", sr_contrl, 3'b101);
    chk("ror_datain", sr_datain, 1'b1);
    chk("ror_busy", busy, 1'b0);
    // back-to-back: load 81, asr x4, shl x1
    drive(1, 3'b001, 4'd0, 8'h81);
    tick();
    drive(1, 3'b100, 4'd3, 8'h00);
    tick();
    chk("b2b_op0", sr_contrl, 3'b001);
    chk("b2b_q0", q_model, 8'hB4);
    drive(1, 3'b011, 4'd0, 8'h00);
    tick();
    drive(0, 3'b000, 4'd0, 8'h00);
    chk("b2b_op1", sr_contrl, 3'b100);
    chk("b2b_q1", q_model, 8'h81);
    tick();
    chk("b2b_op2", sr_contrl, 3'b100);
    chk("b2b_q2", q_model, 8'hC0);
    tick();
    chk("b2b_op3", sr_contrl, 3'b100);
    chk("b2b_q3", q_model, 8'hE0);
    tick();
    chk("b2b_op4", sr_contrl, 3'b100);
    chk("b2b_q4", q_model, 8'hF0);
    tick();
    chk("b2b_op5", sr_contrl, 3'b011);
    chk("b2b_q5", q_model, 8'hF8);
    tick();
    chk("b2b_hold", sr_contrl, 3'b101);
    chk("b2b_qend", q_model, 8'hF0);
    chk("b2b_busy", busy, 1'b0);
    // six 16-beat rotate-lefts with cmd_valid held high
    drive(1, 3'b111, 4'hF, 8'h00);
    acc = 0;
    beats = 0;
    for (int t = 0; t < 400 && (acc < 6 || busy); t++) begin
      if (cmd_valid && cmd_ready) acc++;
      tick();
      if (acc == 6) cmd_valid = 1'b0;
      if (sr_contrl == 3'b111) beats++;
      if (t == 4) chk("full_ready_drop", cmd_ready, 1'b0);
      if (t == 16) chk("full_ready_held", cmd_ready, 1'b0);
      if (t == 17) chk("full_ready_back", cmd_ready, 1'b1);
    end
    chk("full_accepted", acc, 6);
    chk("full_beats", beats, 96);
    chk("full_drained", busy, 1'b0);
    chk("full_q", q_model, 8'hF0);
    chk("full_hold", sr_contrl, 3'b101);
    // reset during a running shift-right with one command queued
    drive(1, 3'b010, 4'd7, 8'h00);
    tick();
    drive(1, 3'b001, 4'd0, 8'h55);
    tick();
    drive(0, 3'b000, 4'd0, 8'h00);
    chk("abort_contrl", sr_contrl, 3'b010);
    chk("abort_q0", q_model, 8'hF0);
    tick();
    chk("abort_q1", q_model, 8'h78);
    tick();
    chk("abort_q2", q_model, 8'h3C);
    chk("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_contrl", sr_contrl, 3'b000);
    chk("abort_rst_q", q_model, 8'h00);
    chk("abort_rst_busy", busy, 1'b0);
    chk("abort_rst_ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_abort_contrl", sr_contrl, 3'b101);
      chk("post_abort_q", q_model, 8'h00);
      chk("post_abort_busy", busy, 1'b0);
`ifdef SHIFT_SEQ_DONE_EN
      chk("post_abort_done", done, 1'b0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
